// File: rtl/crossbar2_sched.sv
// Packet scheduler for the 2x2 Crossbar2: per-output arbitration, packet-locked grants and select drive.
// Build option CB_RR_EN: per-output round-robin contention (default build is fixed priority, X0 wins).
module crossbar2_sched #(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = 5,
  localparam int unsigned SEL_W    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             DST0,
  input  logic             LAST0,
  output logic             RDY0,
  input  logic             REQ1,
  input  logic             DST1,
  input  logic             LAST1,
  output logic             RDY1,
  input  logic             OUT_RDY0,
  input  logic             OUT_RDY1,
  output logic             OUT_VLD0,
  output logic             OUT_VLD1,
  output logic [SEL_W-1:0] S0,
  output logic [SEL_W-1:0] S1
);

  logic [1:0] req_c, dst_c, last_c, out_rdy_c;
  logic [1:0] busy_q, busy_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0][SEL_W-1:0] sel_q, sel_d;
  logic [1:0] vld_c, rdy_c, xfer_c;
`ifdef CB_RR_EN
  logic [1:0] ptr_q, ptr_d;
`endif

  assign req_c     = {REQ1, REQ0};
  assign dst_c     = {DST1, DST0};
  assign last_c    = {LAST1, LAST0};
  assign out_rdy_c = {OUT_RDY1, OUT_RDY0};

  // State register: one IDLE/BUSY FSM per output plus its owner, beat count and select.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q  <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
`ifdef CB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
`ifdef CB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Output decode: a busy output forwards its owner's valid and the sink's ready.
  always_comb begin
    vld_c  = '0;
    rdy_c  = '0;
    xfer_c = '0;
    for (int k = 0; k < 2; k++) begin
      if (busy_q[k]) begin
        vld_c[k]          = req_c[owner_q[k]];
        xfer_c[k]         = req_c[owner_q[k]] & out_rdy_c[k];
        rdy_c[owner_q[k]] = rdy_c[owner_q[k]] | xfer_c[k];
      end
    end
  end

  // Next state: release on last/limit beat, otherwise grant from idle among eligible requesters.
  always_comb begin
    logic [1:0]       cand;
    logic             pick;
    logic [CNT_W-1:0] cnt_inc;
    busy_d  = busy_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
`ifdef CB_RR_EN
    ptr_d   = ptr_q;
`endif
    cand    = '0;
    pick    = 1'b0;
    cnt_inc = '0;
    for (int k = 0; k < 2; k++) begin
      cnt_inc = cnt_q[k] + CNT_W'(1);
      for (int i = 0; i < 2; i++) begin
        cand[i] = req_c[i] & (dst_c[i] == 1'(k)) &
                  ~(busy_q[1-k] & (owner_q[1-k] == 1'(i)));
      end
      if (busy_q[k]) begin
        if (xfer_c[k]) begin
          if (last_c[owner_q[k]] || (MAX_BEATS != 0 && cnt_inc == CNT_W'(MAX_BEATS))) begin
            busy_d[k] = 1'b0;
            sel_d[k]  = '0;
            cnt_d[k]  = '0;
`ifdef CB_RR_EN
            ptr_d[k]  = ~owner_q[k];
`endif
          end else begin
            cnt_d[k] = cnt_inc;
          end
        end
      end else if (|cand) begin
`ifdef CB_RR_EN
        pick = (&cand) ? ptr_q[k] : cand[1];
`else
        pick = cand[1] & ~cand[0];
`endif
        busy_d[k]  = 1'b1;
        owner_d[k] = pick;
        cnt_d[k]   = '0;
        sel_d[k]   = pick ? SEL_W'(2'b10) : SEL_W'(2'b01);
      end
    end
  end

  assign RDY0     = rdy_c[0];
  assign RDY1     = rdy_c[1];
  assign OUT_VLD0 = vld_c[0];
  assign OUT_VLD1 = vld_c[1];
  assign S0       = sel_q[0];
  assign S1       = sel_q[1];

endmodule
